// File: rtl/cpkt_seg.sv
// ---------------------------------------------------------------------------
// cpkt_seg : packet-to-cell segmenter feeding the tcp_rx cell mixer.
//
// Cuts a keyed, variable-length packet stream into fixed CELL_LEN-beat cells.
// The last cell of a packet is zero-padded. Each cell leaves as one unbroken
// burst: out_soc on beat 0 and out_key constant across the cell, so the
// mixer's per-queue FIFOs only ever hold whole cells. Two ping-pong cell
// buffers (B0/B1) decouple packet ingress from cell egress.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pkt_vld/pkt_rdy    ingress beat handshake
//   pkt_data           ingress beat data (DWID)
//   pkt_sop/pkt_eop    first / last beat of a packet
//   pkt_key            queue key, sampled on the sop beat
//   out_vld            egress cell beat valid (mixer in_vld)
//   out_data           egress cell beat data (DWID)
//   out_soc            start of cell (beat 0)
//   out_key            key of the cell being sent
//   out_rdy            mixer space available, looked at only at cell start
//   dbg_sig            status: [1:0] full flags, [2] sending, [3] in-packet,
//                      [15:8] protocol error count (saturating)
//
// Optional build macro CPKT_SEG_STAT_EN: adds 16-bit wrapping counters of
// cells emitted (dbg_sig[31:16]) and padded beats (pad_cnt_q, low nibble on
// dbg_sig[7:4]). Without it those dbg_sig bits read 0.
// dbg_sig is assumed to be at least 32 bits wide.
// ---------------------------------------------------------------------------
module cpkt_seg #(
    parameter int DWID     = 256,
    parameter int CELL_LEN = 4,
    parameter int KEY_WID  = 16,
    parameter int DBG_WID  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pkt_vld,
    input  logic [DWID-1:0]    pkt_data,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [KEY_WID-1:0] pkt_key,
    output logic               pkt_rdy,
    output logic               out_vld,
    output logic [DWID-1:0]    out_data,
    output logic               out_soc,
    output logic [KEY_WID-1:0] out_key,
    input  logic               out_rdy,
    output logic [DBG_WID-1:0] dbg_sig
);

    localparam int IW = $clog2(CELL_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(CELL_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // cell buffers (data is never read before it has been written or padded)
    logic [DWID-1:0]    buf_data_q [2][CELL_LEN];
    logic [KEY_WID-1:0] buf_key_q  [2];

    // fill side
    logic [1:0]         full_q;
    logic               fill_ptr_q;
    logic [IW-1:0]      wr_idx_q;
    logic               in_pkt_q;
    logic [KEY_WID-1:0] key_q;
    logic [7:0]         err_cnt_q;
    logic               rdy_en_q;

    // drain side
    state_t             state_q, state_d;
    logic               drain_ptr_q;
    logic [IW-1:0]      rd_idx_q, rd_idx_d;
    logic               out_vld_q, out_vld_d;
    logic               out_soc_q, out_soc_d;
    logic [DWID-1:0]    out_data_q, out_data_d;
    logic [KEY_WID-1:0] out_key_q, out_key_d;
    logic               free_buf;

    // fill control
    logic               sop_err;
    logic               accept;
    logic               drop_beat;
    logic               wr_en;
    logic               close_wr;
    logic               close_err;
    logic               close_cell;
    logic               zero_en;
    logic [IW:0]        pad_from;
    logic [IW:0]        pad_beats;
    logic [DBG_WID-1:0] dbg_w;
    logic [IW-1:0]      rd_next;

`ifdef CPKT_SEG_STAT_EN
    logic [15:0]        cell_cnt_q;
    logic [15:0]        pad_cnt_q;
`endif

    // A sop arriving mid-packet closes the partial cell this cycle and is
    // held off; it is taken on the next cycle into the other buffer.
    assign sop_err   = rdy_en_q & pkt_vld & pkt_sop & in_pkt_q;
    assign pkt_rdy   = rdy_en_q & ~full_q[fill_ptr_q] & ~sop_err;
    assign accept    = pkt_vld & pkt_rdy;
    assign drop_beat = accept & ~pkt_sop & ~in_pkt_q;
    assign wr_en     = accept & (pkt_sop | in_pkt_q);
    assign close_wr  = wr_en & (pkt_eop | (wr_idx_q == LAST_IDX));
    // wr_idx 0 means the previous beat already closed a cell; nothing to pad
    assign close_err = sop_err & (wr_idx_q != '0);
    assign close_cell = close_wr | close_err;

    // Slots from pad_from upward are zeroed when a cell closes short.
    assign zero_en   = (wr_en & pkt_eop) | close_err;
    assign pad_from  = close_err ? {1'b0, wr_idx_q} : ({1'b0, wr_idx_q} + (IW+1)'(1));
    assign pad_beats = (IW+1)'(CELL_LEN) - pad_from;

    // Cell buffer storage: write the accepted beat, stamp the packet key
    // into the cell, and clear the unused tail so padding reads as zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_data_q[fill_ptr_q][wr_idx_q] <= pkt_data;
            buf_key_q[fill_ptr_q]            <= pkt_sop ? pkt_key : key_q;
        end
        if (zero_en) begin
            for (int j = 0; j < CELL_LEN; j++) begin
                if ((IW+1)'(j) >= pad_from) begin
                    buf_data_q[fill_ptr_q][j] <= '0;
                end
            end
        end
    end

    // Fill-side bookkeeping: write index, packet state, full flags, pointers
    // and the error counter. The drain side frees a buffer here too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            wr_idx_q    <= '0;
            in_pkt_q    <= 1'b0;
            key_q       <= '0;
            err_cnt_q   <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;

            if (close_cell) begin
                wr_idx_q   <= '0;
                fill_ptr_q <= ~fill_ptr_q;
            end else if (wr_en) begin
                wr_idx_q <= wr_idx_q + IW'(1);
            end

            if (sop_err) begin
                in_pkt_q <= 1'b0;
            end else if (wr_en) begin
                in_pkt_q <= ~pkt_eop;
            end

            if (wr_en && pkt_sop) begin
                key_q <= pkt_key;
            end

            // set and clear never target the same buffer in one cycle
            if (close_cell) begin
                full_q[fill_ptr_q] <= 1'b1;
            end
            if (free_buf) begin
                full_q[drain_ptr_q] <= 1'b0;
                drain_ptr_q         <= ~drain_ptr_q;
            end

            if ((sop_err || drop_beat) && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Drain FSM state and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_idx_q   <= '0;
            out_vld_q  <= 1'b0;
            out_soc_q  <= 1'b0;
            out_data_q <= '0;
            out_key_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            out_vld_q  <= out_vld_d;
            out_soc_q  <= out_soc_d;
            out_data_q <= out_data_d;
            out_key_q  <= out_key_d;
        end
    end

    assign rd_next = rd_idx_q + IW'(1);

    // Drain FSM next state. A cell starts only when its buffer is full and
    // the mixer has room; once started it runs to completion regardless of
    // out_rdy. The last beat frees the buffer and may chain straight into
    // the other buffer so back-to-back cells have no gap.
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        out_vld_d  = 1'b0;
        out_soc_d  = 1'b0;
        out_data_d = out_data_q;
        out_key_d  = out_key_q;
        free_buf   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[drain_ptr_q] && out_rdy) begin
                    state_d    = ST_SEND;
                    rd_idx_d   = '0;
                    out_vld_d  = 1'b1;
                    out_soc_d  = 1'b1;
                    out_data_d = buf_data_q[drain_ptr_q][0];
                    out_key_d  = buf_key_q[drain_ptr_q];
                end
            end
            ST_SEND: begin
                if (rd_idx_q == LAST_IDX) begin
                    free_buf = 1'b1;
                    if (full_q[~drain_ptr_q] && out_rdy) begin
                        rd_idx_d   = '0;
                        out_vld_d  = 1'b1;
                        out_soc_d  = 1'b1;
                        out_data_d = buf_data_q[~drain_ptr_q][0];
                        out_key_d  = buf_key_q[~drain_ptr_q];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rd_idx_d   = rd_next;
                    out_vld_d  = 1'b1;
                    out_data_d = buf_data_q[drain_ptr_q][rd_next];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef CPKT_SEG_STAT_EN
    // Wrapping statistics: cells started and zero beats inserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_cnt_q <= '0;
            pad_cnt_q  <= '0;
        end else begin
            if (out_soc_d) begin
                cell_cnt_q <= cell_cnt_q + 16'd1;
            end
            if (close_cell) begin
                pad_cnt_q <= pad_cnt_q + 16'(pad_beats);
            end
        end
    end
`endif

    // Debug/status word assembly.
    always_comb begin
        dbg_w       = '0;
        dbg_w[1:0]  = full_q;
        dbg_w[2]    = (state_q == ST_SEND);
        dbg_w[3]    = in_pkt_q;
        dbg_w[15:8] = err_cnt_q;
`ifdef CPKT_SEG_STAT_EN
        dbg_w[7:4]   = pad_cnt_q[3:0];
        dbg_w[31:16] = cell_cnt_q;
`endif
    end

    assign dbg_sig  = dbg_w;
    assign out_vld  = out_vld_q;
    assign out_soc  = out_soc_q;
    assign out_data = out_data_q;
    assign out_key  = out_key_q;

endmodule
